// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register, next-PC select and imem handshake tracking for fetch.
// Optional branch/redirect statistics counters are enabled by defining PC_BRANCH_STATS_EN.
module pc_fetch_ctrl #(
   parameter int               PC_W     = 16,
   parameter logic [PC_W-1:0]  RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             imem_ready,
   input  logic             bcomp_en,
   input  logic [7:0]       br_imm,
   input  logic             jmp_disp_en,
   input  logic [10:0]      jmp_disp,
   input  logic             jmp_reg_en,
   input  logic [PC_W-1:0]  jmp_reg_target,
   input  logic [PC_W-1:0]  dec_pc_plus2,
   input  logic             halt,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  pc_plus2,
   output logic             fetch_valid,
   output logic             flush,
   output logic             halted
`ifdef PC_BRANCH_STATS_EN
   ,
   output logic [15:0]      br_taken_cnt,
   output logic [15:0]      redirect_cnt
`endif
);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;
   // Encoding order doubles as request priority: larger value wins.
   typedef enum logic [2:0] {R_NONE, R_BR, R_J, R_JR, R_HALT} req_t;

   state_t           state;
   req_t             pend_kind;
   logic [PC_W-1:0]  pend_tgt;

   req_t             req_kind;
   logic [PC_W-1:0]  req_tgt;
   req_t             sel_kind;
   logic [PC_W-1:0]  sel_tgt;

   logic [PC_W-1:0]  br_tgt;
   logic [PC_W-1:0]  j_tgt;
   logic [PC_W-1:0]  jr_tgt;

   assign br_tgt   = dec_pc_plus2 + {{(PC_W-8){br_imm[7]}}, br_imm};
   assign j_tgt    = dec_pc_plus2 + {{(PC_W-11){jmp_disp[10]}}, jmp_disp};
   assign jr_tgt   = jmp_reg_target & ~PC_W'(1);
   assign pc_plus2 = pc + PC_W'(2);

   assign fetch_valid = rst_n && (state == S_RUN) && imem_ready;

   always_comb begin
      req_kind = R_NONE;
      req_tgt  = '0;
      if (halt) begin
         req_kind = R_HALT;
      end else if (jmp_reg_en) begin
         req_kind = R_JR;
         req_tgt  = jr_tgt;
      end else if (jmp_disp_en) begin
         req_kind = R_J;
         req_tgt  = j_tgt;
      end else if (bcomp_en) begin
         req_kind = R_BR;
         req_tgt  = br_tgt;
      end
   end

   // Pending entry is always empty in RUN, so this merge is a no-op there.
   always_comb begin
      sel_kind = pend_kind;
      sel_tgt  = pend_tgt;
      if (req_kind > pend_kind) begin
         sel_kind = req_kind;
         sel_tgt  = req_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_RUN;
         pc           <= RESET_PC;
         pend_kind    <= R_NONE;
         pend_tgt     <= '0;
         flush        <= 1'b0;
         halted       <= 1'b0;
`ifdef PC_BRANCH_STATS_EN
         br_taken_cnt <= '0;
         redirect_cnt <= '0;
`endif
      end else begin
         flush <= 1'b0;
         case (state)
            S_RUN, S_WAIT: begin
               if (!imem_ready) begin
                  state     <= S_WAIT;
                  pend_kind <= sel_kind;
                  pend_tgt  <= sel_tgt;
               end else begin
                  state     <= S_RUN;
                  pend_kind <= R_NONE;
                  pend_tgt  <= '0;
                  if (sel_kind == R_HALT) begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end else if (sel_kind != R_NONE) begin
                     pc    <= sel_tgt;
                     flush <= 1'b1;
`ifdef PC_BRANCH_STATS_EN
                     if (redirect_cnt != 16'hFFFF)
                        redirect_cnt <= redirect_cnt + 16'd1;
                     if ((sel_kind == R_BR) && (br_taken_cnt != 16'hFFFF))
                        br_taken_cnt <= br_taken_cnt + 16'd1;
`endif
                  end else if ((state == S_RUN) && !stall) begin
                     pc <= pc_plus2;
                  end
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl with a behavioural reference model.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        imem_ready;
   logic        bcomp_en;
   logic [7:0]  br_imm;
   logic        jmp_disp_en;
   logic [10:0] jmp_disp;
   logic        jmp_reg_en;
   logic [15:0] jmp_reg_target;
   logic [15:0] dec_pc_plus2;
   logic        halt;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        fetch_valid;
   logic        flush;
   logic        halted;
`ifdef PC_BRANCH_STATS_EN
   logic [15:0] br_taken_cnt;
   logic [15:0] redirect_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pc_fetch_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready),
      .bcomp_en(bcomp_en), .br_imm(br_imm), .jmp_disp_en(jmp_disp_en),
      .jmp_disp(jmp_disp), .jmp_reg_en(jmp_reg_en), .jmp_reg_target(jmp_reg_target),
      .dec_pc_plus2(dec_pc_plus2), .halt(halt), .pc(pc), .pc_plus2(pc_plus2),
      .fetch_valid(fetch_valid), .flush(flush), .halted(halted)
`ifdef PC_BRANCH_STATS_EN
      , .br_taken_cnt(br_taken_cnt), .redirect_cnt(redirect_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0=running, 1=waiting on memory, 2=halted.
   // Request kinds ranked by priority: 0 none, 1 branch, 2 J, 3 JR, 4 halt.
   int m_ok = 0;
   int m_mode, m_pc, m_pend, m_ptgt, m_flush, m_halted, m_br, m_rd;

   function automatic int sext(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   always @(posedge clk) begin
      int k, t, was;
      if (!rst_n) begin
         m_ok = 1; m_mode = 0; m_pc = 0; m_pend = 0; m_ptgt = 0;
         m_flush = 0; m_halted = 0; m_br = 0; m_rd = 0;
      end else if (m_ok != 0) begin
         k = 0; t = 0;
         if (halt) k = 4;
         else if (jmp_reg_en) begin k = 3; t = int'(jmp_reg_target) / 2 * 2; end
         else if (jmp_disp_en) begin k = 2; t = (int'(dec_pc_plus2) + sext(int'(jmp_disp), 11)) & 16'hFFFF; end
         else if (bcomp_en) begin k = 1; t = (int'(dec_pc_plus2) + sext(int'(br_imm), 8)) & 16'hFFFF; end
         if (m_pend >= k) begin k = m_pend; t = m_ptgt; end
         m_flush = 0;
         if (m_mode == 2) begin
         end else if (!imem_ready) begin
            m_mode = 1; m_pend = k; m_ptgt = t;
         end else begin
            was = m_mode; m_mode = 0; m_pend = 0;
            if (k == 4) begin
               m_mode = 2; m_halted = 1;
            end else if (k != 0) begin
               m_pc = t; m_flush = 1;
               if (m_rd < 65535) m_rd++;
               if (k == 1 && m_br < 65535) m_br++;
            end else if (was == 0 && !stall) begin
               m_pc = (m_pc + 2) % 65536;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok != 0) begin
         check("pc", 32'(pc), 32'(m_pc));
         check("pc_plus2", 32'(pc_plus2), 32'((m_pc + 2) % 65536));
         check("fetch_valid", 32'(fetch_valid), 32'((rst_n && m_mode == 0 && imem_ready) ? 1 : 0));
         check("flush", 32'(flush), 32'(m_flush));
         check("halted", 32'(halted), 32'(m_halted));
`ifdef PC_BRANCH_STATS_EN
         check("br_taken_cnt", 32'(br_taken_cnt), 32'(m_br));
         check("redirect_cnt", 32'(redirect_cnt), 32'(m_rd));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      stall = 0; bcomp_en = 0; jmp_disp_en = 0; jmp_reg_en = 0; halt = 0;
      br_imm = 0; jmp_disp = 0; jmp_reg_target = 0; dec_pc_plus2 = 0;
   endtask

   task automatic rand_inputs();
      stall          = ($urandom_range(0, 3) == 0);
      imem_ready     = ($urandom_range(0, 3) != 0);
      bcomp_en       = ($urandom_range(0, 2) == 0);
      jmp_disp_en    = ($urandom_range(0, 5) == 0);
      jmp_reg_en     = ($urandom_range(0, 5) == 0);
      halt           = ($urandom_range(0, 99) == 0);
      br_imm         = 8'($urandom);
      jmp_disp       = 11'($urandom);
      jmp_reg_target = 16'($urandom);
      dec_pc_plus2   = 16'($urandom);
   endtask

   initial begin
      idle();
      rst_n = 0; imem_ready = 0;
      tick(); tick();
      check("reset pc", 32'(pc), 32'h0000);
      check("reset flush", 32'(flush), 0);
      check("reset halted", 32'(halted), 0);
      check("reset fetch_valid", 32'(fetch_valid), 0);

      rst_n = 1; imem_ready = 1;
      tick();
      check("run fetch_valid", 32'(fetch_valid), 1);
      check("run pc 1", 32'(pc), 32'h0002);
      tick();
      check("run pc 2", 32'(pc), 32'h0004);
      tick();
      check("run pc 3", 32'(pc), 32'h0006);
      check("run flush", 32'(flush), 0);

      dec_pc_plus2 = 16'h0010; br_imm = 8'hFC; bcomp_en = 1;
      tick();
      check("branch pc", 32'(pc), 32'h000C);
      check("branch flush", 32'(flush), 1);
      bcomp_en = 0;
      tick();
      check("branch seq pc", 32'(pc), 32'h000E);
      check("branch flush end", 32'(flush), 0);

      bcomp_en = 1; jmp_reg_en = 1; jmp_reg_target = 16'h0041;
      tick();
      check("prio jr pc", 32'(pc), 32'h0040);
      jmp_reg_en = 0; jmp_disp_en = 1; dec_pc_plus2 = 16'h0200; jmp_disp = 11'h010; br_imm = 8'h20;
      tick();
      check("prio j pc", 32'(pc), 32'h0210);
      check("b2b flush", 32'(flush), 1);
      idle();
      tick();
      check("prio seq pc", 32'(pc), 32'h0212);
      check("prio flush end", 32'(flush), 0);

      imem_ready = 0;
      tick();
      check("wait pc 1", 32'(pc), 32'h0212);
      jmp_disp_en = 1; dec_pc_plus2 = 16'h0100; jmp_disp = 11'h7FE;
      check("wait fetch_valid", 32'(fetch_valid), 0);
      tick();
      check("wait pc 2", 32'(pc), 32'h0212);
      jmp_disp_en = 0;
      tick();
      check("wait pc 3", 32'(pc), 32'h0212);
      imem_ready = 1;
      check("wait exit fetch_valid", 32'(fetch_valid), 0);
      tick();
      check("pending pc", 32'(pc), 32'h00FE);
      check("pending flush", 32'(flush), 1);
      tick();
      check("pending seq pc", 32'(pc), 32'h0100);
      check("pending flush end", 32'(flush), 0);

      jmp_reg_en = 1; jmp_reg_target = 16'hFFFF;
      tick();
      check("wrap jr pc", 32'(pc), 32'hFFFE);
      check("wrap pc_plus2", 32'(pc_plus2), 32'h0000);
      jmp_reg_en = 0;
      tick();
      check("wrap pc", 32'(pc), 32'h0000);
      tick();
      check("post wrap pc", 32'(pc), 32'h0002);

      halt = 1; bcomp_en = 1;
      tick();
      check("halt pc", 32'(pc), 32'h0002);
      check("halt halted", 32'(halted), 1);
      for (int i = 0; i < 8; i++) begin
         rand_inputs();
         rst_n = 1;
         tick();
         check("halt frozen pc", 32'(pc), 32'h0002);
         check("halt stays", 32'(halted), 1);
         check("halt fetch_valid", 32'(fetch_valid), 0);
      end
      idle();
      rst_n = 0;
      tick();
      check("halt reset pc", 32'(pc), 32'h0000);
      check("halt reset halted", 32'(halted), 0);

      rst_n = 1; imem_ready = 1; bcomp_en = 1; br_imm = 8'h08; dec_pc_plus2 = 16'h0300;
      tick(); tick(); tick();
      bcomp_en = 0; jmp_reg_en = 1; jmp_reg_target = 16'h0500;
      tick();
      idle();
      tick();
      check("stats pc", 32'(pc), 32'h0502);
`ifdef PC_BRANCH_STATS_EN
      check("stats br_taken_cnt", 32'(br_taken_cnt), 3);
      check("stats redirect_cnt", 32'(redirect_cnt), 4);
`endif

      for (int i = 0; i < 4000; i++) begin
         rand_inputs();
         rst_n = ($urandom_range(0, 199) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-control stage directly downstream of the branch comparator.
- Consumes the branch-taken flag plus jump requests from decode and computes the next PC: sequential, conditional branch or jump.
- Owns the PC register and tracks the instruction-memory handshake.
- Flags the wrong-path instruction to squash on every redirect and freezes the machine on HALT.

Parameters:
- PC_W, 16, PC/address width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  hazard hold from decode; PC must not advance.
- imem_ready  in  1  instruction memory has returned the word for the current pc.
- bcomp_en  in  1  conditional branch taken (from branch comparator).
- br_imm  in  8  branch immediate, sign-extended internally.
- jmp_disp_en  in  1  J/JAL displacement jump request.
- jmp_disp  in  11  jump displacement, sign-extended internally.
- jmp_reg_en  in  1  JR/JALR register jump request.
- jmp_reg_target  in  PC_W  precomputed Rs+imm target.
- dec_pc_plus2  in  PC_W  PC+2 of the instruction currently in decode; base for branch/J targets.
- halt  in  1  HALT decoded.
- pc  out  PC_W  current fetch address.
- pc_plus2  out  PC_W  pc + 2, wraps modulo 2^PC_W.
- fetch_valid  out  1  pc's instruction word is valid this cycle.
- flush  out  1  squash the instruction fetched behind a redirect.
- halted  out  1  machine frozen.

Behaviour:
- Reset (rst_n=0 at a clk edge): pc=RESET_PC, state=RUN, pending redirect cleared.
  - fetch_valid=0, flush=0, halted=0.
  - Reset mid-WAIT or in HALT also returns to RUN.
- Targets, all arithmetic modulo 2^PC_W:
  - branch target = dec_pc_plus2 + sext(br_imm).
  - J target = dec_pc_plus2 + sext(jmp_disp).
  - register target = jmp_reg_target; bit0 is forced to 0.
- Redirect priority, when more than one request is asserted in the same cycle: halt > jmp_reg_en > jmp_disp_en > bcomp_en > sequential (pc+2).
- States:
  - RUN:
    - fetch_valid = imem_ready.
    - If imem_ready=0: go to WAIT, hold pc.
    - Else, if halt: go to HALT, hold pc.
    - Else, if a redirect is requested: pc <= target, and flush=1 for exactly the following cycle.
    - Else, if stall=0: pc <= pc+2.
    - stall=1 holds pc and drops no redirect: the redirect still applies in the same cycle, so redirect beats stall.
  - WAIT:
    - fetch_valid=0; pc is held.
    - A redirect or halt arriving in WAIT is captured in a one-entry pending register; a later, higher-priority request overwrites it.
    - On imem_ready=1: go to RUN.
      - If a redirect is pending: apply it as in RUN (pc update, flush pulse next cycle) and clear the pending register.
      - Pending halt: go to HALT instead.
  - HALT:
    - halted=1 from the cycle after entry onward; fetch_valid=0; pc is frozen.
    - All inputs are ignored until reset.
- Latency:
  - A redirect sampled at edge N makes pc = target after edge N.
  - flush is high during cycle N+1 only.
- Back-to-back redirects: each is applied on its own edge; flush stays high continuously.
- pc_plus2 is combinational from pc.
  - pc=16'hFFFE gives pc_plus2=16'h0000; sequential fetch wraps to 0 without error.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_taken_cnt [15:0] and redirect_cnt [15:0].
  - br_taken_cnt increments on each applied bcomp_en redirect.
  - redirect_cnt increments on every applied redirect of any kind.
  - Both saturate at 16'hFFFF, reset to 0, and freeze in HALT.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then run: rst_n=0 for 2 cycles, then imem_ready=1, no redirects → pc goes 0000, 0002, 0004, 0006 on successive cycles; flush=0; fetch_valid=1 after the first post-reset cycle.
- Taken branch: dec_pc_plus2=0010, br_imm=8'hFC, bcomp_en=1 for one cycle → next pc=000C; flush=1 for exactly one cycle; then pc=000E.
- Priority: bcomp_en=1 and jmp_reg_en=1 with jmp_reg_target=0041 in the same cycle → next pc=0040; jmp_disp_en plus bcomp_en → J target wins.
- Memory stall with pending redirect:
  - Stimulus: imem_ready=0 for 3 cycles; jmp_disp_en=1 (dec_pc_plus2=0100, jmp_disp=11'h7FE) during the 2nd cycle.
  - Required: pc held for all 3 cycles and fetch_valid=0; after imem_ready=1, pc=00FE, then flush=1 for one cycle.
- Halt: halt=1 with bcomp_en=1 → pc unchanged; halted=1 next cycle and stays 1 under any input; rst_n=0 restores pc=0000, halted=0.
- Wrap and stats: pc=FFFE sequential → 0000; with PC_BRANCH_STATS_EN, 3 taken branches plus 1 JR → br_taken_cnt=3, redirect_cnt=4.
